// File: rtl/wb_pipe_pkg.sv
// Shared types and constants for the writeback stage and its load extractor.
package wb_pipe_pkg;
  localparam int XLEN_DEF = 32;
  localparam int RA_DEF   = 5;

  typedef enum logic [1:0] {
    LS_BYTE  = 2'b00,
    LS_HALF  = 2'b01,
    LS_WORD  = 2'b10,
    LS_DWORD = 2'b11
  } load_size_t;

  // Default-width stage entry; parameterised modules declare an equivalent type.
  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [RA_DEF-1:0]   rd;
    logic                we;
  } wb_entry_t;
endpackage

// File: rtl/wb_pipe_if.sv
// MEM -> WB request bus with valid/ready handshake.
interface wb_pipe_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  localparam int OFS_W = $clog2(XLEN/8);

  logic             mem_valid;
  logic             mem_ready;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  load_word;
  logic [OFS_W-1:0] addr_ofs;
  logic [1:0]       load_size;
  logic             load_unsigned;
  logic [RA_W-1:0]  rd;
  logic             reg_write;
  logic             memtoreg;

  modport master (
    output mem_valid, alu_result, load_word, addr_ofs, load_size,
           load_unsigned, rd, reg_write, memtoreg,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, alu_result, load_word, addr_ofs, load_size,
           load_unsigned, rd, reg_write, memtoreg,
    output mem_ready
  );
endinterface

// File: rtl/wb_pipe_load_extract.sv
// Sub-word lane select and sign/zero extension of a raw aligned memory word.
module load_extract
  import wb_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  localparam int OFS_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  load_word,
  input  logic [OFS_W-1:0] addr_ofs,
  input  logic [1:0]       load_size,
  input  logic             load_unsigned,
  output logic [XLEN-1:0]  out
);
  load_size_t       eff;
  logic [OFS_W-1:0] lane;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  mask;
  logic             sbit;

  always_comb begin
    eff = load_size_t'(load_size);
    if (XLEN == 32 && eff == LS_DWORD) eff = LS_WORD;

    case (eff)
      LS_BYTE: lane = addr_ofs;
      LS_HALF: lane = addr_ofs & ~OFS_W'(1);
      LS_WORD: lane = addr_ofs & ~OFS_W'(3);
      default: lane = '0;
    endcase

    shifted = load_word >> {lane, 3'b000};

    // Mask-based extension avoids zero-width replication when the field is XLEN wide.
    case (eff)
      LS_BYTE: begin mask = XLEN'(8'hFF);        sbit = shifted[7];      end
      LS_HALF: begin mask = XLEN'(16'hFFFF);     sbit = shifted[15];     end
      LS_WORD: begin mask = XLEN'(32'hFFFF_FFFF); sbit = shifted[31];    end
      default: begin mask = '1;                  sbit = shifted[XLEN-1]; end
    endcase

    out = (shifted & mask) | ((!load_unsigned && sbit) ? ~mask : '0);
  end
endmodule

// File: rtl/wb_pipe.sv
// Writeback stage: MEM/WB register, load extension at capture, RF write port, bypass, retire counter.
module wb_pipe
  import wb_pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  wb_pipe_if.slave         mem,
  input  logic             wb_stall,
  input  logic             flush,
  output logic [XLEN-1:0]  wb_write_data,
  output logic [RA_W-1:0]  wb_write_addr,
  output logic             wb_write_en,
  output logic             fwd_valid,
  output logic [RA_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] retire_count
);
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RA_W-1:0] rd;
    logic            we;
  } entry_t;

  logic            valid_q;
  entry_t          ent_q;
  entry_t          ent_d;
  logic [XLEN-1:0] ext_load;
  logic            fire;
  logic            accept;
  logic            live;

  load_extract #(.XLEN(XLEN)) u_ext (
    .load_word     (mem.load_word),
    .addr_ofs      (mem.addr_ofs),
    .load_size     (mem.load_size),
    .load_unsigned (mem.load_unsigned),
    .out           (ext_load)
  );

  assign mem.mem_ready = !valid_q || !wb_stall;
  assign fire          = valid_q && !wb_stall;
  assign accept        = mem.mem_valid && mem.mem_ready && !flush;

  always_comb begin
    ent_d        = '0;
    ent_d.result = mem.memtoreg ? ext_load : mem.alu_result;
    ent_d.rd     = mem.rd;
    ent_d.we     = mem.reg_write;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      ent_q        <= '0;
      retire_count <= '0;
    end else begin
      // Flush only blocks capture; a firing entry still commits.
      if (accept) begin
        valid_q <= 1'b1;
        ent_q   <= ent_d;
      end else if (fire || flush) begin
        valid_q <= 1'b0;
      end
      if (fire) retire_count <= retire_count + 1'b1;
    end
  end

  assign live          = ent_q.we && (ent_q.rd != '0);
  assign wb_write_en   = fire && live;
  assign wb_write_addr = wb_write_en ? ent_q.rd : '0;
  assign wb_write_data = wb_write_en ? ent_q.result : '0;

  assign fwd_valid = valid_q && live;
  assign fwd_rd    = ent_q.rd;
  assign fwd_data  = ent_q.result;
endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench for wb_pipe: vector table for load extraction plus handshake corner sequences.
module tb_wb_pipe;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_stall, flush;
  logic [XLEN-1:0]  wb_write_data, fwd_data;
  logic [RA_W-1:0]  wb_write_addr, fwd_rd;
  logic             wb_write_en, fwd_valid;
  logic [CNT_W-1:0] retire_count;

  wb_pipe_if #(.XLEN(XLEN), .RA_W(RA_W)) mif ();

  wb_pipe #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (mif.slave),
    .wb_stall      (wb_stall),
    .flush         (flush),
    .wb_write_data (wb_write_data),
    .wb_write_addr (wb_write_addr),
    .wb_write_en   (wb_write_en),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [RA_W-1:0] addr;
    logic [XLEN-1:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [31:0] word;
    logic [31:0] alu;
    logic [1:0]  ofs;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] word, input logic [31:0] alu,
                       input logic [1:0] ofs, input logic [1:0] size, input logic uns,
                       input logic [4:0] r, input logic rw, input logic m2r);
    mif.mem_valid     = v;
    mif.load_word     = word;
    mif.alu_result    = alu;
    mif.addr_ofs      = ofs;
    mif.load_size     = size;
    mif.load_unsigned = uns;
    mif.rd            = r;
    mif.reg_write     = rw;
    mif.memtoreg      = m2r;
  endtask

  task automatic alu_op(input logic [4:0] r, input logic [31:0] v);
    drive(1'b1, 32'h0, v, 2'd0, 2'd2, 1'b0, r, 1'b1, 1'b0);
  endtask

  // Scoreboard: every RF write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wb_write_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write act=%0h:%0h exp=none", wb_write_addr, wb_write_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wb_write_addr !== e.addr || wb_write_data !== e.data) begin
          errors++;
          $display("FAIL sb_write act=%0h:%0h exp=%0h:%0h", wb_write_addr, wb_write_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    logic [CNT_W-1:0] exp_cnt;
    vecs[0]  = '{32'h80FF_7F01, 32'h0, 2'd2, 2'b00, 1'b0, 5'd5,  1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[1]  = '{32'h80FF_7F01, 32'h0, 2'd2, 2'b00, 1'b1, 5'd5,  1'b1, 1'b1, 32'h0000_00FF, 1'b1};
    vecs[2]  = '{32'h8001_1234, 32'h0, 2'd3, 2'b01, 1'b0, 5'd6,  1'b1, 1'b1, 32'hFFFF_8001, 1'b1};
    vecs[3]  = '{32'h8001_1234, 32'h0, 2'd0, 2'b01, 1'b0, 5'd7,  1'b1, 1'b1, 32'h0000_1234, 1'b1};
    vecs[4]  = '{32'h8001_1234, 32'h0, 2'd0, 2'b10, 1'b0, 5'd8,  1'b1, 1'b1, 32'h8001_1234, 1'b1};
    vecs[5]  = '{32'h80FF_7F01, 32'h0, 2'd1, 2'b00, 1'b0, 5'd9,  1'b1, 1'b1, 32'h0000_007F, 1'b1};
    vecs[6]  = '{32'h80FF_7F01, 32'h0, 2'd3, 2'b00, 1'b0, 5'd10, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b1};
    vecs[7]  = '{32'h80FF_7F01, 32'h0, 2'd3, 2'b00, 1'b1, 5'd11, 1'b1, 1'b1, 32'h0000_0080, 1'b1};
    vecs[8]  = '{32'h8001_1234, 32'h0, 2'd1, 2'b01, 1'b1, 5'd12, 1'b1, 1'b1, 32'h0000_1234, 1'b1};
    vecs[9]  = '{32'h8001_1234, 32'h0, 2'd1, 2'b11, 1'b1, 5'd13, 1'b1, 1'b1, 32'h8001_1234, 1'b1};
    vecs[10] = '{32'hFFFF_FFFF, 32'h1234_5678, 2'd3, 2'b00, 1'b0, 5'd14, 1'b1, 1'b0, 32'h1234_5678, 1'b1};
    vecs[11] = '{32'h0, 32'hDEAD_BEEF, 2'd0, 2'b10, 1'b0, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{32'h0, 32'hCAFE_0001, 2'd0, 2'b10, 1'b0, 5'd3,  1'b0, 1'b0, 32'hCAFE_0001, 1'b0};

    rst = 1'b1; wb_stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_cnt = '0;
    #1;
    chk("reset_we", wb_write_en, 0);
    chk("reset_fwd", {fwd_valid, fwd_rd, fwd_data}, 0);
    chk("reset_wr", {wb_write_addr, wb_write_data}, 0);
    chk("reset_cnt", retire_count, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_reset_ready", mif.mem_ready, 1);

    // Back-to-back vectors: each one is on the write port the cycle after it is driven.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].word, vecs[i].alu, vecs[i].ofs, vecs[i].size, vecs[i].uns,
            vecs[i].rd, vecs[i].rw, vecs[i].m2r);
      if (vecs[i].exp_we) sb.push_back('{vecs[i].rd, vecs[i].exp_data});
      tick();
      chk($sformatf("v%0d_we", i), wb_write_en, vecs[i].exp_we);
      chk($sformatf("v%0d_data", i), wb_write_data, vecs[i].exp_we ? vecs[i].exp_data : 32'h0);
      chk($sformatf("v%0d_fwd", i), {fwd_valid, fwd_data}, {vecs[i].exp_we, vecs[i].exp_data});
      exp_cnt++;
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("vec_cnt", retire_count, exp_cnt);
    chk("idle_we", wb_write_en, 0);

    // Stall on the second of three streamed instructions.
    alu_op(5'd1, 32'h11); sb.push_back('{5'd1, 32'h11});
    tick();
    alu_op(5'd2, 32'h22); sb.push_back('{5'd2, 32'h22});
    #1;
    chk("st_a_we", {wb_write_en, wb_write_addr}, {1'b1, 5'd1});
    tick();
    alu_op(5'd3, 32'h33); sb.push_back('{5'd3, 32'h33});
    wb_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("st_hold%0d_ready", k), mif.mem_ready, 0);
      chk($sformatf("st_hold%0d_we", k), wb_write_en, 0);
      chk($sformatf("st_hold%0d_fwd", k), {fwd_valid, fwd_rd, fwd_data}, {1'b1, 5'd2, 32'h22});
      chk($sformatf("st_hold%0d_cnt", k), retire_count, exp_cnt + CNT_W'(1));
      if (k == 0) tick();
    end
    wb_stall = 1'b0;
    #1;
    chk("st_b_we", {wb_write_en, wb_write_addr, wb_write_data}, {1'b1, 5'd2, 32'h22});
    chk("st_b_ready", mif.mem_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("st_c_we", {wb_write_en, wb_write_addr}, {1'b1, 5'd3});
    tick();
    exp_cnt += 3;
    chk("st_cnt", retire_count, exp_cnt);
    chk("st_empty", fwd_valid, 0);

    // Flush of an unfired held entry: no write, no capture.
    alu_op(5'd4, 32'h44);
    tick();
    alu_op(5'd5, 32'h55);
    wb_stall = 1'b1; flush = 1'b1;
    #1;
    chk("fl_we", wb_write_en, 0);
    tick();
    flush = 1'b0; wb_stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("fl_fwd", fwd_valid, 0);
    chk("fl_we2", wb_write_en, 0);
    chk("fl_cnt", retire_count, exp_cnt);

    // Flush in the cycle the held entry fires: write commits, new request dropped.
    alu_op(5'd6, 32'h66); sb.push_back('{5'd6, 32'h66});
    tick();
    alu_op(5'd7, 32'h77); flush = 1'b1;
    #1;
    chk("flf_we", {wb_write_en, wb_write_addr}, {1'b1, 5'd6});
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    exp_cnt++;
    chk("flf_nocap", {fwd_valid, wb_write_en}, 0);
    chk("flf_cnt", retire_count, exp_cnt);

    // Reset pulsed mid-stall.
    alu_op(5'd8, 32'h88);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    wb_stall = 1'b1;
    #1;
    chk("rs_pre_fwd", fwd_valid, 1);
    rst = 1'b1;
    #1;
    chk("rs_outs", {wb_write_en, wb_write_addr, wb_write_data, fwd_valid, fwd_rd, fwd_data}, 0);
    chk("rs_cnt", retire_count, 0);
    tick();
    rst = 1'b0; wb_stall = 1'b0;
    #1;
    chk("rs_ready", mif.mem_ready, 1);
    exp_cnt = '0;

    // 17 fires through a 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h0, 32'(i), 2'd0, 2'd2, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("wrap_cnt", retire_count, 4'd1);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_pipe.md
Name: wb_pipe

Overview:
- Parametrised writeback stage with an integrated MEM/WB stage register, valid/ready handshake to MEM, and stall/flush control.
- Extracts and sign- or zero-extends sub-word load data, and drives the register-file write port plus a forwarding bypass.
- Maintains a retired-instruction counter.
- Sits between the MEM stage and the register file / hazard unit.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RA_W, 5, register address width.
- CNT_W, 64, retire counter width.
- OFS_W, $clog2(XLEN/8), byte-offset width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_valid  in  1  MEM presents an instruction
- mem_ready  out  1  stage can accept this cycle
- alu_result  in  XLEN  ALU result
- load_word  in  XLEN  raw aligned memory word
- addr_ofs  in  OFS_W  low address bits of the load
- load_size  in  2  00 byte, 01 half, 10 word, 11 dword (XLEN=64 only)
- load_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- rd  in  RA_W  destination register
- reg_write  in  1  RegWrite
- memtoreg  in  1  select load data
- wb_stall  in  1  hold writeback (register-file port busy)
- flush  in  1  kill the held entry and the same-cycle capture
- wb_write_data  out  XLEN  register-file write data
- wb_write_addr  out  RA_W  register-file write address
- wb_write_en  out  1  register-file write enable
- fwd_valid  out  1  bypass value valid
- fwd_rd  out  RA_W  bypass destination
- fwd_data  out  XLEN  bypass value
- retire_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, rst=1): valid_q=0, all stage registers 0, retire_count=0. All write/forward outputs are 0 while reset is asserted. mem_ready=1 on the first cycle after deassertion.
- Reset mid-operation: the held entry is discarded, no write occurs, and the counter clears.
- Stage register contents: valid_q, result_q (the selected and extended value), rd_q, we_q.
- Load data is extended at capture, not at writeback.
- Handshake:
  - mem_ready = !valid_q || !wb_stall (combinational).
  - Accept when mem_valid && mem_ready && !flush.
  - No combinational path from mem_valid to mem_ready.
- Latency: an instruction accepted in cycle N appears on the write port in cycle N+1 if wb_stall=0.
- Writeback fires when valid_q && !wb_stall.
  - wb_write_en = fire && we_q && (rd_q != 0).
  - wb_write_addr = rd_q; wb_write_data = result_q.
  - When wb_write_en=0, addr and data are driven 0.
- Stall: with valid_q=1 and wb_stall=1, the entry holds, outputs show it with wb_write_en=0, mem_ready=0, and the counter does not increment.
- Fire and accept in the same cycle: the new entry replaces the old one with no bubble, giving full throughput.
- Fire without accept: valid_q goes to 0.
- Flush:
  - Next cycle valid_q=0, and there is no capture that cycle.
  - If the held entry fires in the flush cycle, its write still occurs and it counts as retired (the write is committed).
  - Flush has priority over accept.
- Forwarding:
  - fwd_valid = valid_q && we_q && (rd_q != 0).
  - fwd_rd = rd_q; fwd_data = result_q.
  - Forwarding is valid even while stalled.
- Result select: memtoreg ? ext_load : alu_result.
- Load extraction:
  - byte: lane = addr_ofs.
  - half: lane = addr_ofs with bit 0 forced to 0.
  - word: lane = addr_ofs with bits[1:0] forced to 0.
  - dword: the whole word, no shift.
  - The selected field is sign-extended (load_unsigned=0) or zero-extended to XLEN.
  - Word loads with XLEN=32 pass through unchanged regardless of load_unsigned.
  - load_size=11 with XLEN=32 is treated as word.
  - Misalignment is the MEM stage's concern; low offset bits are silently ignored.
- retire_count increments by 1 on every fire, including rd=0 and reg_write=0. It wraps from all-ones to 0.

Decomposition:
- Shared package:
  - load_size encodings LS_BYTE/LS_HALF/LS_WORD/LS_DWORD.
  - XLEN default.
  - wb_entry_t struct {result, rd, we}.
- One natural sub-module: load_extract (combinational lane select plus extension; ports load_word, addr_ofs, load_size, load_unsigned, out). It is reused by the future LSU.

Test Plan:
- Byte load: load_word=32'h80FF_7F01, addr_ofs=2, size=byte, signed, rd=5, reg_write=1, memtoreg=1 -> next cycle wb_write_en=1, addr=5, data=32'hFFFF_FFFF; same with unsigned -> 32'h0000_00FF.
- Half and word loads, XLEN=32: load_word=32'h8001_1234, half, offset 3, signed -> data=32'hFFFF_8001; half, offset 0 -> 32'h0000_1234; word -> 32'h8001_1234.
- x0 suppression: rd=0, reg_write=1, alu_result=32'hDEAD_BEEF -> wb_write_en=0, fwd_valid=0, retire_count +1.
- Stall plus back-to-back: three instructions streamed with wb_stall high for 2 cycles on the second -> mem_ready=0 during the stall, fwd stays valid for the held entry, writes occur in order, no loss or duplication, retire_count=3.
- Flush and reset: flush while holding an unfired entry under stall, with a new mem_valid -> no write, valid_q=0, count unchanged; rst pulsed mid-stall -> all outputs 0 immediately, count 0.
- Counter wrap with CNT_W=4: 17 fires -> retire_count=1.
